// File: rtl/alu_exec_sequencer_pkg.sv
// rtl/alu_exec_sequencer_pkg.sv - op classes, branch codes, FSM states and flag positions
package alu_exec_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_BRANCH = 2'b01;

  localparam logic [2:0] BR_ALWAYS = 3'b000;
  localparam logic [2:0] BR_Z      = 3'b001;
  localparam logic [2:0] BR_NZ     = 3'b010;
  localparam logic [2:0] BR_C      = 3'b011;
  localparam logic [2:0] BR_NC     = 3'b100;
  localparam logic [2:0] BR_S      = 3'b101;
  localparam logic [2:0] BR_NS     = 3'b110;
  localparam logic [2:0] BR_V      = 3'b111;

  // flags_q layout is {C,S,V,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition check against {C,S,V,Z}
module branch_cond_eval
  import alu_exec_sequencer_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_ALWAYS: taken = 1'b1;
      BR_Z:      taken = flags[FLAG_Z];
      BR_NZ:     taken = !flags[FLAG_Z];
      BR_C:      taken = flags[FLAG_C];
      BR_NC:     taken = !flags[FLAG_C];
      BR_S:      taken = flags[FLAG_S];
      BR_NS:     taken = !flags[FLAG_S];
      BR_V:      taken = flags[FLAG_V];
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - execute-stage sequencer driving the ALU, flag register and branch resolve
// Optional: EXEC_BRANCH_FAST_EN resolves branches at accept and skips EXEC for them.
module alu_exec_sequencer
  import alu_exec_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op_class,
  input  logic [2:0]        in_alu_ctrl,
  input  logic [DATA_W-1:0] in_op0,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [2:0]        in_br_cond,
  input  logic [DATA_W-1:0] in_br_target,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] operand0,
  output logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              carryflag,
  input  logic              signflag,
  input  logic              overflowflag,
  input  logic              zflag,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              br_valid,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic [3:0]        flags_q
);

  state_t              state_q, state_d;
  logic [1:0]          class_q, class_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   op0_q, op0_d, op1_q, op1_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [DATA_W-1:0]   target_q, target_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                taken_q, taken_d;
  logic [3:0]          flags_d;
  logic [2:0]          eval_cond;
  logic                eval_taken;
  logic                accept;

  assign accept = in_valid && (state_q == ST_IDLE);

`ifdef EXEC_BRANCH_FAST_EN
  assign eval_cond = in_br_cond;
`else
  logic [2:0] cond_q, cond_d;
  assign eval_cond = cond_q;
`endif

  branch_cond_eval u_cond (
    .cond  (eval_cond),
    .flags (flags_q),
    .taken (eval_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      class_q  <= '0;
      ctrl_q   <= '0;
      op0_q    <= '0;
      op1_q    <= '0;
      rd_q     <= '0;
      target_q <= '0;
      result_q <= '0;
      taken_q  <= 1'b0;
      flags_q  <= '0;
`ifndef EXEC_BRANCH_FAST_EN
      cond_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      class_q  <= class_d;
      ctrl_q   <= ctrl_d;
      op0_q    <= op0_d;
      op1_q    <= op1_d;
      rd_q     <= rd_d;
      target_q <= target_d;
      result_q <= result_d;
      taken_q  <= taken_d;
      flags_q  <= flags_d;
`ifndef EXEC_BRANCH_FAST_EN
      cond_q   <= cond_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef EXEC_BRANCH_FAST_EN
          state_d = (in_op_class == CLS_BRANCH) ? ST_DONE : ST_EXEC;
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    class_d  = class_q;
    ctrl_d   = ctrl_q;
    op0_d    = op0_q;
    op1_d    = op1_q;
    rd_d     = rd_q;
    target_d = target_q;
    result_d = result_q;
    taken_d  = taken_q;
    flags_d  = flags_q;
`ifndef EXEC_BRANCH_FAST_EN
    cond_d   = cond_q;
`endif
    if (accept) begin
      class_d  = in_op_class;
      ctrl_d   = in_alu_ctrl;
      op0_d    = in_op0;
      op1_d    = in_op1;
      rd_d     = in_rd;
      target_d = in_br_target;
`ifdef EXEC_BRANCH_FAST_EN
      taken_d  = eval_taken;
`else
      cond_d   = in_br_cond;
`endif
    end
    if (state_q == ST_EXEC) begin
      result_d = alu_result;
      if (class_q == CLS_ALU) flags_d = {carryflag, signflag, overflowflag, zflag};
`ifndef EXEC_BRANCH_FAST_EN
      taken_d  = eval_taken;
`endif
    end
  end

  // Pulses and their payloads read 0 except during the single DONE cycle.
  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    alu_control = ctrl_q;
    operand0    = op0_q;
    operand1    = op1_q;
    wb_valid    = (state_q == ST_DONE) && (class_q == CLS_ALU);
    wb_rd       = wb_valid ? rd_q : '0;
    wb_data     = wb_valid ? result_q : '0;
    br_valid    = (state_q == ST_DONE) && (class_q == CLS_BRANCH);
    br_taken    = br_valid && taken_q;
    br_target   = br_valid ? target_q : '0;
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb/tb_alu_exec_sequencer.sv - table-driven bench for alu_exec_sequencer
module tb_alu_exec_sequencer;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
`ifdef EXEC_BRANCH_FAST_EN
  localparam int BR_LAT = 1;
`else
  localparam int BR_LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op_class;
  logic [2:0]        in_alu_ctrl;
  logic [DATA_W-1:0] in_op0, in_op1;
  logic [REG_W-1:0]  in_rd;
  logic [2:0]        in_br_cond;
  logic [DATA_W-1:0] in_br_target;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] operand0, operand1;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] tbl_result;
  logic [3:0]        alu_flags;
  logic              use_add_model;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              br_valid, br_taken;
  logic [DATA_W-1:0] br_target;
  logic [3:0]        flags_q;

  always #5 clk = ~clk;

  assign alu_result = use_add_model ? (operand0 + operand1) : tbl_result;

  alu_exec_sequencer #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_class(in_op_class), .in_alu_ctrl(in_alu_ctrl), .in_op0(in_op0), .in_op1(in_op1),
    .in_rd(in_rd), .in_br_cond(in_br_cond), .in_br_target(in_br_target),
    .alu_control(alu_control), .operand0(operand0), .operand1(operand1),
    .alu_result(alu_result), .carryflag(alu_flags[3]), .signflag(alu_flags[2]),
    .overflowflag(alu_flags[1]), .zflag(alu_flags[0]),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target), .flags_q(flags_q)
  );

  typedef struct {
    logic [1:0]  cls;
    logic [2:0]  ctrl;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [4:0]  rd;
    logic [2:0]  cond;
    logic [31:0] target;
    logic [31:0] res;
    logic [3:0]  aflags;
    logic [31:0] exp_data;
    logic        exp_taken;
    logic [3:0]  exp_flags;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit is_alu, is_br;
    is_alu = (v.cls == 2'b00);
    is_br  = (v.cls == 2'b01);
    in_op_class = v.cls; in_alu_ctrl = v.ctrl; in_op0 = v.op0; in_op1 = v.op1;
    in_rd = v.rd; in_br_cond = v.cond; in_br_target = v.target;
    tbl_result = v.res; alu_flags = v.aflags;
    in_valid = 1'b1;
    chk($sformatf("v%0d ready_before", idx), in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d alu_control", idx), alu_control, v.ctrl);
        chk($sformatf("v%0d operand0", idx), operand0, v.op0);
        chk($sformatf("v%0d operand1", idx), operand1, v.op1);
        chk($sformatf("v%0d ready_busy", idx), in_ready, 1'b0);
      end
      chk($sformatf("v%0d wb_valid k%0d", idx, k), wb_valid, is_alu && k == 2);
      chk($sformatf("v%0d br_valid k%0d", idx, k), br_valid, is_br && k == BR_LAT);
      if (is_alu && k == 2) begin
        chk($sformatf("v%0d wb_rd", idx), wb_rd, v.rd);
        chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
      end
      if (is_br && k == BR_LAT) begin
        chk($sformatf("v%0d br_taken", idx), br_taken, v.exp_taken);
        chk($sformatf("v%0d br_target", idx), br_target, v.target);
      end
    end
    chk($sformatf("v%0d flags_q", idx), flags_q, v.exp_flags);
    chk($sformatf("v%0d ready_after", idx), in_ready, 1'b1);
  endtask

  vec_t vecs[$];

  initial begin
    int accept_cyc[4];
    int n_acc, n_wb, cyc;
    bit will_acc;
    logic [31:0] b2b_a[4];
    logic [31:0] b2b_b[4];

    // cls ctrl op0 op1 rd cond target res aflags exp_data exp_taken exp_flags
    vecs.push_back('{2'b00, 3'b010, 32'd10, 32'd15, 5'd3, 3'b000, 32'h0, 32'd25, 4'b0000, 32'd25, 1'b0, 4'b0000});
    vecs.push_back('{2'b00, 3'b110, 32'd5, 32'd5, 5'd4, 3'b000, 32'h0, 32'd0, 4'b0001, 32'd0, 1'b0, 4'b0001});
    vecs.push_back('{2'b01, 3'b000, 32'h1, 32'h2, 5'd0, 3'b001, 32'h40, 32'hdead, 4'b1110, 32'd0, 1'b1, 4'b0001});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b010, 32'h44, 32'h0, 4'b1110, 32'd0, 1'b0, 4'b0001});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b000, 32'h48, 32'h0, 4'b0000, 32'd0, 1'b1, 4'b0001});
    vecs.push_back('{2'b10, 3'b011, 32'h7, 32'h9, 5'd9, 3'b000, 32'h0, 32'h1234, 4'b1111, 32'd0, 1'b0, 4'b0001});
    vecs.push_back('{2'b00, 3'b111, 32'h7fffffff, 32'h1, 5'd31, 3'b000, 32'h0, 32'h80000000, 4'b1110, 32'h80000000, 1'b0, 4'b1110});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b011, 32'h100, 32'h0, 4'b0000, 32'd0, 1'b1, 4'b1110});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b100, 32'h104, 32'h0, 4'b0000, 32'd0, 1'b0, 4'b1110});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b101, 32'h108, 32'h0, 4'b0000, 32'd0, 1'b1, 4'b1110});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b110, 32'h10c, 32'h0, 4'b0000, 32'd0, 1'b0, 4'b1110});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b111, 32'h110, 32'h0, 4'b0000, 32'd0, 1'b1, 4'b1110});
    vecs.push_back('{2'b00, 3'b000, 32'h3, 32'h2, 5'd7, 3'b000, 32'h0, 32'h1, 4'b0000, 32'h1, 1'b0, 4'b0000});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b001, 32'h200, 32'h0, 4'b0000, 32'd0, 1'b0, 4'b0000});
    vecs.push_back('{2'b01, 3'b000, 32'h0, 32'h0, 5'd0, 3'b100, 32'h204, 32'h0, 4'b0000, 32'd0, 1'b1, 4'b0000});
    vecs.push_back('{2'b11, 3'b000, 32'h0, 32'h0, 5'd0, 3'b000, 32'h208, 32'h0, 4'b1111, 32'd0, 1'b0, 4'b0000});

    rst = 1'b1; in_valid = 1'b0; in_op_class = '0; in_alu_ctrl = '0; in_op0 = '0; in_op1 = '0;
    in_rd = '0; in_br_cond = '0; in_br_target = '0; tbl_result = '0; alu_flags = '0;
    use_add_model = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset wb_valid", wb_valid, 1'b0);
    chk("reset br_valid", br_valid, 1'b0);
    chk("reset flags_q", flags_q, 4'b0000);
    chk("reset operand0", operand0, 32'h0);
    chk("reset alu_control", alu_control, 3'b000);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // back-to-back: in_valid held high, bench ALU adds operands
    use_add_model = 1'b1;
    alu_flags = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      b2b_a[j] = 32'h100 * (j + 1);
      b2b_b[j] = 32'd7 + j;
    end
    n_acc = 0; n_wb = 0; cyc = 0;
    in_op_class = 2'b00; in_alu_ctrl = 3'b010; in_op0 = b2b_a[0]; in_op1 = b2b_b[0];
    in_rd = 5'd10; in_valid = 1'b1;
    while (cyc < 30 && n_wb < 4) begin
      if (wb_valid) begin
        chk($sformatf("b2b wb_rd %0d", n_wb), wb_rd, 5'd10 + n_wb);
        chk($sformatf("b2b wb_data %0d", n_wb), wb_data, b2b_a[n_wb] + b2b_b[n_wb]);
        n_wb++;
      end
      will_acc = in_valid && in_ready;
      @(posedge clk);
      cyc++;
      #1;
      if (will_acc) begin
        accept_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 4) begin
          in_op0 = b2b_a[n_acc]; in_op1 = b2b_b[n_acc]; in_rd = 5'd10 + 5'(n_acc);
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b accepts", n_acc, 4);
    chk("b2b writebacks", n_wb, 4);
    for (int j = 1; j < 4; j++)
      if (j < n_acc) chk($sformatf("b2b gap %0d", j), accept_cyc[j] - accept_cyc[j-1], 3);
    use_add_model = 1'b0;
    repeat (2) @(negedge clk);

    // make flags nonzero, then reset during EXEC of an ADD
    run_vec('{2'b00, 3'b010, 32'h1, 32'h1, 5'd2, 3'b000, 32'h0, 32'h2, 4'b1000, 32'h2, 1'b0, 4'b1000}, 100);
    in_op_class = 2'b00; in_alu_ctrl = 3'b010; in_op0 = 32'd10; in_op1 = 32'd15; in_rd = 5'd3;
    tbl_result = 32'd25; alu_flags = 4'b0000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid in_ready", in_ready, 1'b1);
    chk("rst_mid flags_q", flags_q, 4'b0000);
    chk("rst_mid alu_control", alu_control, 3'b000);
    chk("rst_mid wb_valid0", wb_valid, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid wb_valid%0d", k), wb_valid, 1'b0);
      chk($sformatf("rst_mid br_valid%0d", k), br_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
